// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and control states shared by the sequential ALU.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_NOT  = 4'd3,
    OP_ADD  = 4'd4,
    OP_ADDC = 4'd5,
    OP_SUB  = 4'd6,
    OP_CMP  = 4'd7,
    OP_LSH  = 4'd8,
    OP_ASH  = 4'd9,
    OP_MUL  = 4'd10,
    OP_MOV  = 4'd11
  } op_e;
  localparam int FL_C = 4;
  localparam int FL_L = 3;
  localparam int FL_F = 2;
  localparam int FL_Z = 1;
  localparam int FL_N = 0;
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per clock, low WIDTH bits of the product.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic             run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_nx;
  // product is the accumulator after the current step, so the last step lands directly in the caller
  always_comb begin
    acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = run_q && (cnt_q == CW'(WIDTH - 1));
    product  = acc_nx;
    run_d    = start || (run_q && !done);
    cnt_d    = start ? '0 : run_q ? cnt_q + CW'(1) : cnt_q;
    acc_d    = start ? '0 : run_q ? acc_nx : acc_q;
    mcand_d  = start ? a : run_q ? mcand_q << 1 : mcand_q;
    mplier_d = start ? b : run_q ? mplier_q >> 1 : mplier_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result and {C,L,F,Z,N} flags; MUL runs iteratively.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic             busy
);
  localparam int M = WIDTH - 1;
  state_e           state_q, state_d;
  logic             rdy_q, rdy_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d, alu_r, mul_p, shl, shr, sar;
  logic [4:0]       flags_q, flags_d, alu_f, mag;
  logic [WIDTH:0]   add_s, sub_s;
  logic             accept, mul_start, mul_done, big, cin;

  // rdy_q keeps in_ready low until the first clock after reset release
  assign in_ready  = rdy_q && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign busy      = (state_q == MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .reset_n(reset_n), .start(mul_start), .a(a), .b(b), .done(mul_done), .product(mul_p)
  );

  // shift amount is b[4:0] as a signed value; negative shifts right
  always_comb begin
    mag   = b[4] ? ~b[4:0] + 5'd1 : b[4:0];
    big   = 32'(mag) >= WIDTH;
    shl   = big ? '0 : a << mag;
    shr   = big ? '0 : a >> mag;
    sar   = big ? {WIDTH{a[M]}} : $unsigned($signed(a) >>> mag);
    cin   = (op == OP_ADDC) && flags_q[FL_C];
    add_s = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
    sub_s = {1'b0, a} - {1'b0, b};
  end

  always_comb begin
    alu_r = '0;
    alu_f = flags_q;
    case (op_e'(op))
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      OP_NOT:  alu_r = ~a;
      OP_ADD, OP_ADDC: begin
        alu_r        = add_s[M:0];
        alu_f[FL_C]  = add_s[WIDTH];
        alu_f[FL_F]  = (a[M] == b[M]) && (add_s[M] != a[M]);
      end
      OP_SUB: begin
        alu_r        = sub_s[M:0];
        alu_f[FL_C]  = sub_s[WIDTH];
        alu_f[FL_F]  = (a[M] != b[M]) && (sub_s[M] != a[M]);
      end
      OP_CMP: begin
        alu_r        = a;
        alu_f[FL_L]  = a < b;
      end
      OP_LSH:  alu_r = b[4] ? shr : shl;
      OP_ASH:  alu_r = b[4] ? sar : shl;
      OP_MOV:  alu_r = b;
      default: alu_r = '0;
    endcase
    if (op_e'(op) == OP_CMP) begin
      alu_f[FL_Z] = a == b;
      alu_f[FL_N] = $signed(a) < $signed(b);
    end else if (op <= 4'd11) begin
      alu_f[FL_Z] = alu_r == '0;
      alu_f[FL_N] = alu_r[M];
    end
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    rdy_d       = 1'b1;
    out_valid_d = out_valid_q && !out_ready;
    if (mul_done) begin
      state_d        = IDLE;
      result_d       = mul_p;
      flags_d[FL_Z]  = mul_p == '0;
      flags_d[FL_N]  = mul_p[M];
      out_valid_d    = 1'b1;
    end else if (accept) begin
      if (op == OP_MUL) state_d = MUL;
      else begin
        result_d    = alu_r;
        flags_d     = alu_f;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with a result/flag scoreboard drained by a separate output monitor.
module tb_alu_seq;
  typedef struct {
    string       nm;
    logic [15:0] r;
    logic [4:0]  f;
  } exp_t;

  logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]  op = '0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] result;
  logic [4:0]  flags;
  exp_t        q[$];
  int          errors = 0, checks = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out_valid", {15'd0, out_valid}, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_result"}, {16'd0, result}, {16'd0, e.r});
        chk({e.nm, "_flags"}, {27'd0, flags}, {27'd0, e.f});
      end
    end

  // called at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic issue(input string nm, input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] er, input logic [4:0] ef, input bit push);
    int n = 0;
    exp_t e;
    if (push) begin
      e.nm = nm; e.r = er; e.f = ef;
      q.push_back(e);
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    int n;
    #3;
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {27'd0, flags}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("in_ready_before_clk", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 chk("in_ready_after_clk", {31'd0, in_ready}, 32'd1);

    issue("add_ovf", 4'd4, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 1);
    chk("add_latency", {31'd0, out_valid}, 32'd1);
    issue("sub_borrow", 4'd6, 16'h0003, 16'h0005, 16'hFFFE, 5'b10001, 1);
    issue("addc", 4'd5, 16'h0000, 16'h0000, 16'h0001, 5'b00000, 1);
    issue("add_cf", 4'd4, 16'h8000, 16'h8000, 16'h0000, 5'b10110, 1);
    issue("cmp_neg", 4'd7, 16'hFFFF, 16'h0001, 16'hFFFF, 5'b10101, 1);
    issue("cmp_lt", 4'd7, 16'h0001, 16'hFFFF, 16'h0001, 5'b11100, 1);
    issue("and", 4'd0, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b11100, 1);
    issue("or_zero", 4'd1, 16'h0000, 16'h0000, 16'h0000, 5'b11110, 1);
    issue("xor", 4'd2, 16'hFFFF, 16'h00FF, 16'hFF00, 5'b11101, 1);
    issue("not", 4'd3, 16'hFFFF, 16'h1234, 16'h0000, 5'b11110, 1);
    issue("mov", 4'd11, 16'h1111, 16'h8001, 16'h8001, 5'b11101, 1);
    issue("lsh_l4", 4'd8, 16'h0001, 16'h0004, 16'h0010, 5'b11100, 1);
    issue("lsh_r1", 4'd8, 16'h8000, 16'h001F, 16'h4000, 5'b11100, 1);
    issue("ash_r1", 4'd9, 16'h8000, 16'h001F, 16'hC000, 5'b11101, 1);
    issue("ash_r16", 4'd9, 16'h8000, 16'h0010, 16'hFFFF, 5'b11101, 1);
    issue("lsh_r16", 4'd8, 16'h8000, 16'h0010, 16'h0000, 5'b11110, 1);
    issue("lsh_l15", 4'd8, 16'h0001, 16'h000F, 16'h8000, 5'b11101, 1);
    issue("illegal", 4'd12, 16'h0001, 16'h0001, 16'h0000, 5'b11101, 1);

    issue("mul", 4'd10, 16'h0123, 16'h0010, 16'h1230, 5'b11100, 1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_c%0d", i), {29'd0, busy, in_ready, out_valid}, 32'b100);
    end
    @(negedge clk);
    chk("mul_done_c17", {30'd0, out_valid, busy}, 32'b10);
    @(posedge clk);
    #1 out_ready = 1'b0;

    issue("bp_add", 4'd4, 16'h0001, 16'h0001, 16'h0002, 5'b01000, 1);
    op = 4'd6; a = 16'h0002; b = 16'h0005; in_valid = 1'b1;
    q.push_back('{nm: "bp_sub", r: 16'hFFFD, f: 5'b11001});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_c%0d", i), {9'd0, out_valid, in_ready, flags, result},
          {9'd0, 1'b1, 1'b0, 5'b01000, 16'h0002});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_sub_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    issue("mul_abort", 4'd10, 16'h0003, 16'h0004, 16'h000C, 5'b00000, 0);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("midmul_rst_outs", {23'd0, result, flags, out_valid, busy, in_ready}, 32'd0);
    @(posedge clk); @(posedge clk);
    #2 reset_n = 1'b1;
    saw = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("no_out_after_rst", {31'd0, saw}, 32'd0);
    @(posedge clk);
    #1;
    issue("add_after_rst", 4'd4, 16'h0002, 16'h0003, 16'h0005, 5'b00000, 1);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    #1 chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
